// File: rtl/btn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_pkg                                                            |
// | Shared state type and prescaler helper for the button conditioner. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package btn_pkg;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    DB_PRESS   = 2'd1,
    PRESSED    = 2'd2,
    DB_RELEASE = 2'd3
  } btn_state_t;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_conditioner_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_conditioner_if                                                 |
// | Raw button inputs and conditioned level/strobe outputs.            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface btn_conditioner_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;
  // "release" is a reserved word, hence the suffix
  logic [N_BTN-1:0] release_p;
  logic [N_BTN-1:0] hold;

  modport master (
    output btn_raw,
    input  level,
    input  press,
    input  release_p,
    input  hold
  );

  modport slave (
    input  btn_raw,
    output level,
    output press,
    output release_p,
    output hold
  );
endinterface
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_channel                                                        |
// | One input: 2-flop synchroniser, debounce FSM, long-press counter.  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 1000
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic tick,
  input  wire logic btn_raw,
  output logic      level,
  output logic      press,
  output logic      release_p,
  output logic      hold
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  btn_state_t    state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          hold_q, hold_d;

  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    hold_d     = 1'b0;

    case (state_q)
      RELEASED: begin
        level_d = 1'b0;
        if (sync2_q) begin
          state_d  = DB_PRESS;
          db_cnt_d = '0;
        end
      end
      DB_PRESS: begin
        // An input change wins over a coincident tick: the tick is dropped
        if (!sync2_q) begin
          state_d = RELEASED;
        end else if (tick) begin
          db_cnt_d = db_cnt_q + 1'b1;
          if (db_cnt_q == DB_LAST) begin
            state_d    = PRESSED;
            level_d    = 1'b1;
            press_d    = 1'b1;
            hold_cnt_d = '0;
          end
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        // Hold counting is independent of the release check so both can fire together
        if (tick && (hold_cnt_q < HOLD_MAX)) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
          hold_d     = (hold_cnt_q == HOLD_LAST);
        end
        if (!sync2_q) begin
          state_d  = DB_RELEASE;
          db_cnt_d = '0;
        end
      end
      DB_RELEASE: begin
        if (sync2_q) begin
          state_d = PRESSED;
        end else if (tick) begin
          db_cnt_d = db_cnt_q + 1'b1;
          if (db_cnt_q == DB_LAST) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
          end
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= RELEASED;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      hold_q     <= hold_d;
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_p = release_q;
  assign hold      = hold_q;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | btn_conditioner                                                    |
// | Shared debounce tick prescaler feeding N_BTN independent channels. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN          = 4,
  parameter int CLK_HZ         = 100_000_000,
  parameter int TICK_HZ        = 1000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int HOLD_TICKS     = 1000
) (
  input  wire logic          clk,
  input  wire logic          rst,
  btn_conditioner_if.slave   bus
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             tick;
  logic [N_BTN-1:0] level_w;
  logic [N_BTN-1:0] press_w;
  logic [N_BTN-1:0] release_w;
  logic [N_BTN-1:0] hold_w;

  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .HOLD_TICKS     (HOLD_TICKS)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .btn_raw   (bus.btn_raw[i]),
      .level     (level_w[i]),
      .press     (press_w[i]),
      .release_p (release_w[i]),
      .hold      (hold_w[i])
    );
  end

  assign bus.level     = level_w;
  assign bus.press     = press_w;
  assign bus.release_p = release_w;
  assign bus.hold      = hold_w;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_btn_conditioner                                                 |
// | Randomised bench with a tick-counting reference model.             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_btn_conditioner;

  localparam int N    = 4;
  localparam int DIV  = 10;
  localparam int DEB  = 3;
  localparam int HOLD = 5;

  logic clk = 1'b0;
  logic rst;
  btn_conditioner_if #(.N_BTN(N)) bus ();

  btn_conditioner #(
    .N_BTN          (N),
    .CLK_HZ         (1000),
    .TICK_HZ        (100),
    .DEBOUNCE_TICKS (DEB),
    .HOLD_TICKS     (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a channel flips its level once DEB ticks have elapsed
  // while the synchronised input has stayed opposite to the level; the edge
  // on which the opposite value first appears does not count a tick.
  bit [N-1:0] m_level, m_run_active, r1, r2;
  bit [N-1:0] e_press, e_rel, e_hold;
  int         m_run [N];
  int         m_held[N];
  int         phase;

  task automatic model_edge(input logic [N-1:0] raw, input logic r);
    bit tk;
    bit s;
    e_press = '0; e_rel = '0; e_hold = '0;
    if (r) begin
      m_level = '0; m_run_active = '0; r1 = '0; r2 = '0; phase = 0;
      for (int c = 0; c < N; c++) begin m_run[c] = 0; m_held[c] = 0; end
      return;
    end
    tk    = (phase == DIV - 1);
    phase = (phase + 1) % DIV;
    for (int c = 0; c < N; c++) begin
      s = r2[c];
      if (m_level[c] && !m_run_active[c] && tk && m_held[c] < HOLD) begin
        m_held[c]++;
        if (m_held[c] == HOLD) e_hold[c] = 1'b1;
      end
      if (s == m_level[c]) begin
        m_run_active[c] = 1'b0;
      end else if (!m_run_active[c]) begin
        m_run_active[c] = 1'b1;
        m_run[c] = 0;
      end else if (tk) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_level[c]      = ~m_level[c];
          m_run_active[c] = 1'b0;
          if (m_level[c]) begin
            e_press[c] = 1'b1;
            m_held[c]  = 0;
          end else begin
            e_rel[c] = 1'b1;
          end
        end
      end
    end
    r2 = r1;
    r1 = raw;
  endtask

  logic [N-1:0] raw_v;
  logic [N-1:0] pp = '0, pr = '0, ph = '0;

  task automatic step(input logic [N-1:0] raw, input logic r);
    bus.btn_raw = raw;
    rst = r;
    @(posedge clk);
    model_edge(raw, r);
    cyc++;
    @(negedge clk);
    check("level",   32'(bus.level),     32'(m_level));
    check("press",   32'(bus.press),     32'(e_press));
    check("release", 32'(bus.release_p), 32'(e_rel));
    check("hold",    32'(bus.hold),      32'(e_hold));
    check("strobe_2x", 32'({pp & bus.press, pr & bus.release_p, ph & bus.hold}), 32'd0);
    pp = bus.press; pr = bus.release_p; ph = bus.hold;
  endtask

  function automatic bit hit(input int kind, input int ch);
    case (kind)
      0:       return bus.press[ch];
      1:       return bus.release_p[ch];
      default: return bus.hold[ch];
    endcase
  endfunction

  // Counts edges from the first applied step until the strobe appears, bounded by max
  task automatic run_until(input int kind, input int ch, input int max, output int lat);
    lat = 0;
    step(raw_v, 1'b0);
    while (!hit(kind, ch) && lat < max) begin
      step(raw_v, 1'b0);
      lat++;
    end
  endtask

  function automatic bit in_window(input int lat);
    return (lat >= 3 + (DEB - 1) * DIV) && (lat <= 2 + DEB * DIV);
  endfunction

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(raw_v, 1'b0);
  endtask

  initial begin
    int lat;
    int cnt;
    raw_v = '0;
    for (int c = 0; c < N; c++) begin m_run[c] = 0; m_held[c] = 0; end
    phase = 0;

    step(raw_v, 1'b1);
    step(raw_v, 1'b1);
    check("reset_outputs", 32'({bus.level, bus.press, bus.release_p, bus.hold}), 32'd0);

    // Clean press on channel 0, then one hold strobe only
    idle($urandom_range(0, 9));
    raw_v[0] = 1'b1;
    run_until(0, 0, 60, lat);
    check("press0_in_window", 32'(in_window(lat)), 32'd1);
    run_until(2, 0, 80, lat);
    check("hold0_distance", 32'(lat + 1), 32'd50);
    cnt = 0;
    for (int k = 0; k < 70; k++) begin step(raw_v, 1'b0); cnt += int'(bus.hold[0]); end
    check("hold0_once", 32'(cnt), 32'd0);

    // Short low glitch while pressed
    raw_v[0] = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin step(raw_v, 1'b0); cnt += int'(bus.release_p[0] | bus.hold[0]); end
    raw_v[0] = 1'b1;
    for (int k = 0; k < 60; k++) begin step(raw_v, 1'b0); cnt += int'(bus.release_p[0] | bus.hold[0]); end
    check("glitch0_quiet", 32'(cnt), 32'd0);

    // Release of channel 0
    idle($urandom_range(0, 9));
    raw_v[0] = 1'b0;
    run_until(1, 0, 60, lat);
    check("release0_in_window", 32'(in_window(lat)), 32'd1);

    // Bouncing channel 1
    cnt = 0;
    for (int k = 0; k < 98; k++) begin
      if (k % 7 == 0) raw_v[1] = ~raw_v[1];
      step(raw_v, 1'b0);
      cnt += int'(bus.press[1]);
    end
    check("bounce1_no_press", 32'(cnt), 32'd0);
    raw_v[1] = 1'b1;
    run_until(0, 1, 60, lat);
    check("press1_in_window", 32'(in_window(lat)), 32'd1);

    // Reset during debounce of channel 2
    raw_v[2] = 1'b1;
    idle(12);
    step(raw_v, 1'b1);
    check("rst_mid_outputs", 32'({bus.level, bus.press, bus.release_p, bus.hold}), 32'd0);
    run_until(0, 2, 60, lat);
    check("press2_after_rst", 32'(in_window(lat)), 32'd1);

    // All channels together, then staggered release
    raw_v = '0;
    idle(40);
    raw_v = '1;
    run_until(0, 0, 60, lat);
    check("press_all_same_cycle", 32'(bus.press), 32'hF);
    for (int c = 0; c < N; c++) begin
      raw_v[c] = 1'b0;
      idle($urandom_range(3, 15));
    end
    idle(40);

    // Random traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < N; c++)
        if ($urandom_range(0, 24) == 0) raw_v[c] = ~raw_v[c];
      step(raw_v, ($urandom_range(0, 499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
